huffman_conf_ctrl: RTL and testbench

Configuration sequencer for a bank of N_ENT Huffman single-code detector slots. Each slot holds one symbol/code pair and has en_conf/new_conf inputs. The block accepts a codebook as a valid/ready stream of (symbol, code) entries, clears the bank, then writes one entry per slot through one-hot enables. It reports completion and errors to the decode control, and keeps the bank clean on abort.

---
 rtl/huffman_conf_ctrl.sv | 178 +++++++++++++++++
 tb/tb_huffman_conf_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/huffman_conf_ctrl.sv
// Configuration sequencer for a bank of Huffman single-code detector slots.
// It accepts a codebook as a valid/ready stream of (symbol, code) entries.
// It clears the bank, then writes one entry per slot through one-hot enables.
// On abort it clears the partial table again so that no stale codes can match.
//
// Ports:
//   clk, rst_n  - rising-edge clock, asynchronous active-low reset
//   start       - pulse that begins a load; n_entries is sampled with it
//   n_entries   - number of entries to load, valid range 1..N_ENT
//   abort       - abandon the load in progress (CLEAR/LOAD only)
//   s_valid/s_ready/s_data/s_code - codebook entry stream
//   conf_new    - broadcast clear to all slots
//   conf_en     - one-hot slot write enable
//   conf_d/conf_h - symbol/code presented to the slots
//   busy, done, err, loaded_cnt - status to decode control
module huffman_conf_ctrl #(
  parameter int unsigned D_W   = 4,
  parameter int unsigned C_W   = 4,
  parameter int unsigned N_ENT = 16,
  parameter int unsigned IDX_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [IDX_W:0]     n_entries,
  input  logic               abort,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [D_W-1:0]     s_data,
  input  logic [C_W-1:0]     s_code,
  output logic               conf_new,
  output logic [N_ENT-1:0]   conf_en,
  output logic [D_W-1:0]     conf_d,
  output logic [C_W-1:0]     conf_h,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [IDX_W:0]     loaded_cnt
);

  localparam int unsigned CNT_W = IDX_W + 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_LOAD  = 3'd2,
    S_DONE  = 3'd3,
    S_ABORT = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   n_q, n_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               err_q, err_d;
  logic               conf_new_q, conf_new_d;
  logic [N_ENT-1:0]   conf_en_q, conf_en_d;
  logic [D_W-1:0]     conf_d_q, conf_d_d;
  logic [C_W-1:0]     conf_h_q, conf_h_d;
  logic               done_q, done_d;
  logic               busy_q, busy_d;
  logic               n_ok_c;
  logic               last_c;
  logic               hs_c;

  // Abort has priority over a pending handshake in the same cycle.
  assign s_ready = (state_q == S_LOAD) & ~abort;
  assign hs_c    = s_ready & s_valid;
  assign n_ok_c  = (n_entries != '0) && (n_entries <= CNT_W'(N_ENT));
  assign last_c  = ((CNT_W'(idx_q) + CNT_W'(1)) == n_q);

  // Next-state and registered-output logic.
  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    err_d      = err_q;
    conf_new_d = 1'b0;
    conf_en_d  = '0;
    conf_d_d   = conf_d_q;
    conf_h_d   = conf_h_q;
    done_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (n_ok_c) begin
            n_d        = n_entries;
            err_d      = 1'b0;
            cnt_d      = '0;
            idx_d      = '0;
            conf_new_d = 1'b1;
            state_d    = S_CLEAR;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_CLEAR: begin
        if (abort) begin
          conf_new_d = 1'b1;
          state_d    = S_ABORT;
        end else begin
          idx_d   = '0;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        if (abort) begin
          conf_new_d = 1'b1;
          state_d    = S_ABORT;
        end else if (hs_c) begin
          conf_en_d = N_ENT'(1) << idx_q;
          conf_d_d  = s_data;
          conf_h_d  = s_code;
          idx_d     = idx_q + IDX_W'(1);
          cnt_d     = cnt_q + CNT_W'(1);
          if (last_c) begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      S_ABORT: begin
        err_d   = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      n_q        <= '0;
      idx_q      <= '0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
      conf_new_q <= 1'b0;
      conf_en_q  <= '0;
      conf_d_q   <= '0;
      conf_h_q   <= '0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
      conf_new_q <= conf_new_d;
      conf_en_q  <= conf_en_d;
      conf_d_q   <= conf_d_d;
      conf_h_q   <= conf_h_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
    end
  end

  assign conf_new   = conf_new_q;
  assign conf_en    = conf_en_q;
  assign conf_d     = conf_d_q;
  assign conf_h     = conf_h_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;
  assign loaded_cnt = cnt_q;

endmodule

// File: tb/tb_huffman_conf_ctrl.sv
// Directed bench for huffman_conf_ctrl: inputs change 1 time unit after a rising
// edge, and outputs are sampled on the falling edge.
module tb_huffman_conf_ctrl;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [4:0]  n_entries;
  logic        abort;
  logic        s_valid;
  logic        s_ready;
  logic [3:0]  s_data;
  logic [3:0]  s_code;
  logic        conf_new;
  logic [15:0] conf_en;
  logic [3:0]  conf_d;
  logic [3:0]  conf_h;
  logic        busy;
  logic        done;
  logic        err;
  logic [4:0]  loaded_cnt;

  int checks = 0;
  int errors = 0;

  huffman_conf_ctrl #(.D_W(4), .C_W(4), .N_ENT(16), .IDX_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .n_entries(n_entries),
    .abort(abort), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .s_code(s_code), .conf_new(conf_new), .conf_en(conf_en), .conf_d(conf_d),
    .conf_h(conf_h), .busy(busy), .done(done), .err(err),
    .loaded_cnt(loaded_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic samp();
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; n_entries = '0; abort = 1'b0;
    s_valid = 1'b0; s_data = '0; s_code = '0;

    // Reset state.
    repeat (2) @(posedge clk);
    samp();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_s_ready", 32'(s_ready), 0);
    chk("rst_conf_en", 32'(conf_en), 0);
    chk("rst_conf_new", 32'(conf_new), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_cnt", 32'(loaded_cnt), 0);
    rst_n = 1'b1;
    tick();

    // Basic 3-entry load, s_valid held high.
    start = 1'b1; n_entries = 5'd3; s_valid = 1'b1; s_data = 4'd1; s_code = 4'h2;
    tick();
    start = 1'b0;
    samp();
    chk("t1_clear_new", 32'(conf_new), 1);
    chk("t1_clear_busy", 32'(busy), 1);
    chk("t1_clear_ready", 32'(s_ready), 0);
    tick();
    samp();
    chk("t1_load_ready", 32'(s_ready), 1);
    chk("t1_load_new", 32'(conf_new), 0);
    tick();
    s_data = 4'd2; s_code = 4'h5;
    samp();
    chk("t1_en0", 32'(conf_en), 32'h1);
    chk("t1_d0", 32'(conf_d), 1);
    chk("t1_h0", 32'(conf_h), 2);
    chk("t1_cnt1", 32'(loaded_cnt), 1);
    tick();
    s_data = 4'd3; s_code = 4'hC;
    samp();
    chk("t1_en1", 32'(conf_en), 32'h2);
    chk("t1_d1", 32'(conf_d), 2);
    chk("t1_h1", 32'(conf_h), 5);
    tick();
    s_valid = 1'b0;
    samp();
    chk("t1_en2", 32'(conf_en), 32'h4);
    chk("t1_d2", 32'(conf_d), 3);
    chk("t1_h2", 32'(conf_h), 32'hC);
    chk("t1_busy_done_state", 32'(busy), 1);
    chk("t1_ready_after_last", 32'(s_ready), 0);
    chk("t1_no_done_yet", 32'(done), 0);
    tick();
    samp();
    chk("t1_done", 32'(done), 1);
    chk("t1_done_busy", 32'(busy), 0);
    chk("t1_done_en", 32'(conf_en), 0);
    chk("t1_hold_d", 32'(conf_d), 3);
    chk("t1_cnt", 32'(loaded_cnt), 3);
    chk("t1_err", 32'(err), 0);
    tick();
    samp();
    chk("t1_done_pulse", 32'(done), 0);

    // Full 16-entry load with gapped s_valid.
    tick();
    start = 1'b1; n_entries = 5'd16;
    tick();
    start = 1'b0;
    samp();
    chk("t2_clear_new", 32'(conf_new), 1);
    tick();
    for (int i = 0; i < 16; i++) begin
      s_valid = 1'b1; s_data = 4'(i); s_code = 4'(15 - i);
      samp();
      chk($sformatf("t2_ready_%0d", i), 32'(s_ready), 1);
      chk($sformatf("t2_gap_en_%0d", i), 32'(conf_en), 0);
      tick();
      s_valid = 1'b0;
      samp();
      chk($sformatf("t2_en_%0d", i), 32'(conf_en), 32'h1 << i);
      chk($sformatf("t2_d_%0d", i), 32'(conf_d), 32'(i));
      chk($sformatf("t2_h_%0d", i), 32'(conf_h), 32'(15 - i));
      chk($sformatf("t2_done_low_%0d", i), 32'(done), 0);
      if (i == 15) chk("t2_ready_drop", 32'(s_ready), 0);
      tick();
    end
    samp();
    chk("t2_done", 32'(done), 1);
    chk("t2_busy", 32'(busy), 0);
    chk("t2_cnt", 32'(loaded_cnt), 16);

    // Out-of-range n_entries.
    tick();
    start = 1'b1; n_entries = 5'd0;
    tick();
    start = 1'b0;
    samp();
    chk("t3_err0", 32'(err), 1);
    chk("t3_busy0", 32'(busy), 0);
    chk("t3_new0", 32'(conf_new), 0);
    tick();
    start = 1'b1; n_entries = 5'd17;
    tick();
    start = 1'b0;
    samp();
    chk("t3_err17", 32'(err), 1);
    chk("t3_busy17", 32'(busy), 0);
    chk("t3_new17", 32'(conf_new), 0);
    tick();
    start = 1'b1; n_entries = 5'd1;
    tick();
    start = 1'b0;
    samp();
    chk("t3_err_clr", 32'(err), 0);
    chk("t3_new_ok", 32'(conf_new), 1);
    chk("t3_cnt_clr", 32'(loaded_cnt), 0);
    tick();
    s_valid = 1'b1; s_data = 4'd5; s_code = 4'd9;
    tick();
    s_valid = 1'b0;
    samp();
    chk("t3_en", 32'(conf_en), 1);
    tick();
    samp();
    chk("t3_done", 32'(done), 1);
    chk("t3_cnt", 32'(loaded_cnt), 1);

    // Abort after two handshakes with s_valid high in the abort cycle.
    tick();
    start = 1'b1; n_entries = 5'd4;
    tick();
    start = 1'b0;
    tick();
    s_valid = 1'b1; s_data = 4'hA; s_code = 4'h1;
    tick();
    s_data = 4'hB; s_code = 4'h2;
    tick();
    abort = 1'b1; s_data = 4'hC; s_code = 4'h3;
    samp();
    chk("t4_ready_abort", 32'(s_ready), 0);
    chk("t4_en1", 32'(conf_en), 2);
    tick();
    abort = 1'b0; s_valid = 1'b0;
    samp();
    chk("t4_no_en", 32'(conf_en), 0);
    chk("t4_new", 32'(conf_new), 1);
    chk("t4_busy", 32'(busy), 1);
    chk("t4_cnt_a", 32'(loaded_cnt), 2);
    tick();
    samp();
    chk("t4_err", 32'(err), 1);
    chk("t4_idle", 32'(busy), 0);
    chk("t4_no_done", 32'(done), 0);
    chk("t4_new_end", 32'(conf_new), 0);
    chk("t4_cnt", 32'(loaded_cnt), 2);
    chk("t4_hold_d", 32'(conf_d), 32'hB);
    tick();
    samp();
    chk("t4_no_done2", 32'(done), 0);

    // Abort in IDLE has no effect.
    abort = 1'b1;
    tick();
    abort = 1'b0;
    samp();
    chk("t5_idle_abort_busy", 32'(busy), 0);
    chk("t5_idle_abort_new", 32'(conf_new), 0);
    chk("t5_idle_abort_err", 32'(err), 1);

    // Start during LOAD is ignored; original n_entries=2 is kept.
    start = 1'b1; n_entries = 5'd2;
    tick();
    start = 1'b0;
    tick();
    s_valid = 1'b1; s_data = 4'd7; s_code = 4'd1; start = 1'b1; n_entries = 5'd5;
    tick();
    start = 1'b0; s_data = 4'd8; s_code = 4'd2;
    samp();
    chk("t6_en0", 32'(conf_en), 1);
    chk("t6_no_new", 32'(conf_new), 0);
    tick();
    s_valid = 1'b0;
    samp();
    chk("t6_en1", 32'(conf_en), 2);
    chk("t6_h1", 32'(conf_h), 2);
    tick();
    samp();
    chk("t6_done", 32'(done), 1);
    chk("t6_cnt", 32'(loaded_cnt), 2);
    chk("t6_err_clr", 32'(err), 0);

    // Start and abort together in IDLE: start wins.
    tick();
    start = 1'b1; abort = 1'b1; n_entries = 5'd1;
    tick();
    start = 1'b0; abort = 1'b0;
    samp();
    chk("t7_new", 32'(conf_new), 1);
    chk("t7_busy", 32'(busy), 1);
    tick();
    s_valid = 1'b1; s_data = 4'd4; s_code = 4'd6;
    tick();
    s_valid = 1'b0;
    tick();
    samp();
    chk("t7_done", 32'(done), 1);
    chk("t7_err", 32'(err), 0);

    // Asynchronous reset mid-LOAD, then a full reload.
    tick();
    start = 1'b1; n_entries = 5'd3;
    tick();
    start = 1'b0;
    tick();
    s_valid = 1'b1; s_data = 4'd9; s_code = 4'd3;
    tick();
    rst_n = 1'b0;
    #1;
    chk("t8_rst_en", 32'(conf_en), 0);
    chk("t8_rst_busy", 32'(busy), 0);
    chk("t8_rst_ready", 32'(s_ready), 0);
    chk("t8_rst_cnt", 32'(loaded_cnt), 0);
    chk("t8_rst_d", 32'(conf_d), 0);
    s_valid = 1'b0;
    samp();
    rst_n = 1'b1;
    tick();
    start = 1'b1; n_entries = 5'd2;
    tick();
    start = 1'b0;
    samp();
    chk("t8_new", 32'(conf_new), 1);
    tick();
    s_valid = 1'b1; s_data = 4'd1; s_code = 4'd7;
    tick();
    s_data = 4'd2; s_code = 4'd8;
    samp();
    chk("t8_en0", 32'(conf_en), 1);
    tick();
    s_valid = 1'b0;
    samp();
    chk("t8_en1", 32'(conf_en), 2);
    chk("t8_d1", 32'(conf_d), 2);
    tick();
    samp();
    chk("t8_done", 32'(done), 1);
    chk("t8_cnt", 32'(loaded_cnt), 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
